// File: rtl/credit_sender_pkg.sv
// rtl/credit_sender_pkg.sv - shared state encoding and sizing helper for credit_sender
package credit_sender_pkg;

    typedef enum logic [1:0] {
        FULL_CREDIT = 2'd0,
        ACTIVE      = 2'd1,
        STALLED     = 2'd2
    } cs_state_e;

    function automatic int cs_cnt_width(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/credit_counter.sv
// rtl/credit_counter.sv - up/down credit counter saturating at CREDITS, load restores CREDITS
module credit_counter
    import credit_sender_pkg::*;
#(
    parameter int CREDITS   = 8,
    parameter int CNT_WIDTH = cs_cnt_width(CREDITS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic                 inc_i,
    input  logic                 dec_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 zero_o,
    output logic                 max_o,
    output logic                 overflow_o
);

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(CREDITS);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] count_d, count_q;

    assign zero_o  = (count_q == '0);
    assign max_o   = (count_q == MAX_CNT);
    assign count_o = count_q;

    always_comb begin
        count_d    = count_q;
        overflow_o = 1'b0;
        if (load_i) begin
            count_d = MAX_CNT;
        end else if (inc_i && !dec_i) begin
            // A return with every credit already home is dropped, not wrapped.
            if (max_o) overflow_o = 1'b1;
            else       count_d    = count_q + ONE;
        end else if (dec_i && !inc_i && !zero_o) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) count_q <= MAX_CNT;
        else       count_q <= count_d;
    end

endmodule

// File: rtl/credit_sender.sv
// rtl/credit_sender.sv - credit-based push sender into a remote FIFO; CREDIT_SENDER_ERR_CHECK_EN enables overflow flag and checks
module credit_sender
    import credit_sender_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int CREDITS    = 8,
    localparam int CNT_WIDTH  = cs_cnt_width(CREDITS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  credit_i,
    output logic [CNT_WIDTH-1:0]  credits_o,
    output logic                  idle_o,
    output logic                  error_o
);

    cs_state_e             state_d, state_q;
    logic                  valid_d, valid_q;
    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic                  send;
    logic                  cnt_zero, cnt_max, overflow;
    logic [CNT_WIDTH-1:0]  count;

    credit_counter #(
        .CREDITS   (CREDITS),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_counter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (flush_i),
        .inc_i      (credit_i),
        .dec_i      (send),
        .count_o    (count),
        .zero_o     (cnt_zero),
        .max_o      (cnt_max),
        .overflow_o (overflow)
    );

    // Ready never looks at valid_i, so the producer sees no combinational loop.
    assign ready_o   = !rst_i && !cnt_zero && !flush_i;
    assign send      = valid_i && ready_o;
    assign credits_o = count;
    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign idle_o    = (state_q == FULL_CREDIT) && !valid_q;

    always_comb begin
        valid_d = send;
        data_d  = send ? data_i : data_q;
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = FULL_CREDIT;
        end else begin
            case (state_q)
                FULL_CREDIT: if (send && !credit_i)
                    state_d = (CREDITS == 1) ? STALLED : ACTIVE;
                ACTIVE: begin
                    if (send && !credit_i && count == CNT_WIDTH'(1))
                        state_d = STALLED;
                    else if (credit_i && !send && count == CNT_WIDTH'(CREDITS - 1))
                        state_d = FULL_CREDIT;
                end
                STALLED: if (credit_i)
                    state_d = (CREDITS == 1) ? FULL_CREDIT : ACTIVE;
                default: state_d = FULL_CREDIT;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FULL_CREDIT;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

`ifdef CREDIT_SENDER_ERR_CHECK_EN
    logic error_d, error_q;

    always_comb begin
        error_d = flush_i ? 1'b0 : (error_q || overflow);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) error_q <= 1'b0;
        else       error_q <= error_d;
    end

    assign error_o = error_q;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(credit_i && cnt_max && !send && !flush_i))
        else $warning("credit_sender: credit returned with all credits home");

    a_data_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_i && !ready_o) |=> (!valid_i || $stable(data_i)))
        else $error("credit_sender: data_i changed while stalled");

    a_credits_nonzero: assert property (@(posedge clk_i) CREDITS >= 1)
        else $error("credit_sender: CREDITS must be at least 1");
`else
    logic unused_overflow;
    assign unused_overflow = overflow;
    assign error_o         = 1'b0;
`endif

endmodule
